alu_decode: RTL

//   Decode stage feeding the ALU: turns one RV32I instruction word into an ALU op code,

---
 rtl/alu_decode_if.sv | 61 ++++++
 rtl/alu_decode.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decode_if
//  Description : Handshake and bundle signals between fetch, the ALU decode
//                stage and execute.
//                slave  - the decode stage (consumes instr_i/pc_i from fetch,
//                         produces the decoded bundle for execute)
//                master - the surrounding pipeline (fetch + execute side)
//  Signals     : in_valid_i/in_ready_o/instr_i/pc_i   fetch side handshake
//                flush_i                              branch-redirect discard
//                out_valid_o/out_ready_i              execute side handshake
//                alu_op_o, sel_a_o, sel_b_o, imm_o,
//                rs1_o, rs2_o, rd_o, rd_we_o, br_o,
//                br_funct3_o, jump_o, ld_o, st_o,
//                illegal_o, pc_o                      decoded bundle
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_decode_if #(
    parameter int XLEN = 32
);
    // fetch side
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic            flush_i;

    // execute side
    logic            out_valid_o;
    logic            out_ready_i;
    logic [3:0]      alu_op_o;
    logic [1:0]      sel_a_o;
    logic            sel_b_o;
    logic [XLEN-1:0] imm_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;
    logic [4:0]      rd_o;
    logic            rd_we_o;
    logic            br_o;
    logic [2:0]      br_funct3_o;
    logic            jump_o;
    logic            ld_o;
    logic            st_o;
    logic            illegal_o;
    logic [XLEN-1:0] pc_o;

    modport master (
        output in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, alu_op_o, sel_a_o, sel_b_o, imm_o,
               rs1_o, rs2_o, rd_o, rd_we_o, br_o, br_funct3_o, jump_o,
               ld_o, st_o, illegal_o, pc_o
    );

    modport slave (
        input  in_valid_i, instr_i, pc_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, alu_op_o, sel_a_o, sel_b_o, imm_o,
               rs1_o, rs2_o, rd_o, rd_we_o, br_o, br_funct3_o, jump_o,
               ld_o, st_o, illegal_o, pc_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decode
//  Description : RV32I decode stage in front of the ALU. Decodes one
//                instruction word into ALU op, operand selects, immediate,
//                register fields and control flags, held in a single output
//                register (1-cycle latency, 1/cycle throughput).
//  Ports       : clk_i  - clock, rising edge
//                rst_i  - asynchronous reset, active-low
//                bus    - alu_decode_if.slave (fetch handshake, flush,
//                         execute handshake and decoded bundle)
//  Parameters  : XLEN     - pc/imm width (only 32 is supported)
//                RESET_PC - pc_o value after reset
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decode #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    alu_decode_if.slave  bus
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;

    localparam logic [3:0] c_ALU_ADD    = 4'b0000;
    localparam logic [3:0] c_ALU_SUB    = 4'b1000;

    localparam logic [1:0] c_SEL_A_RS1  = 2'd0;
    localparam logic [1:0] c_SEL_A_PC   = 2'd1;
    localparam logic [1:0] c_SEL_A_ZERO = 2'd2;
    localparam logic       c_SEL_B_RS2  = 1'b0;
    localparam logic       c_SEL_B_IMM  = 1'b1;

    localparam logic [6:0] c_F7_ZERO    = 7'b0000000;
    localparam logic [6:0] c_F7_ALT     = 7'b0100000;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_funct7;

    assign w_instr  = bus.instr_i;
    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_funct3 = w_instr[14:12];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_funct7 = w_instr[31:25];

    // Immediate formats, built at 32 bits
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_shamt;

    assign w_imm_i     = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s     = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b     = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                          w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u     = {w_instr[31:12], 12'b0};
    assign w_imm_j     = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                          w_instr[20], w_instr[30:21], 1'b0};
    // Shift-immediates carry only the shift amount; the funct7 bits above
    // it select SRL/SRA and must not leak into the operand.
    assign w_imm_shamt = {27'b0, w_instr[24:20]};

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [3:0]  w_alu_op;
    logic [1:0]  w_sel_a;
    logic        w_sel_b;
    logic [31:0] w_imm32;
    logic        w_writes_rd;
    logic        w_br_raw;
    logic        w_jump_raw;
    logic        w_ld_raw;
    logic        w_st_raw;
    logic        w_illegal;

    always_comb begin
        w_alu_op    = c_ALU_ADD;
        w_sel_a     = c_SEL_A_RS1;
        w_sel_b     = c_SEL_B_RS2;
        w_imm32     = 32'b0;
        w_writes_rd = 1'b0;
        w_br_raw    = 1'b0;
        w_jump_raw  = 1'b0;
        w_ld_raw    = 1'b0;
        w_st_raw    = 1'b0;
        w_illegal   = 1'b0;

        case (w_opcode)
            c_OPC_OP: begin
                w_alu_op    = {w_funct7[5], w_funct3};
                w_writes_rd = 1'b1;
                if (w_funct7 == c_F7_ZERO) begin
                    w_illegal = 1'b0;
                end else if ((w_funct7 == c_F7_ALT) &&
                             ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))) begin
                    w_illegal = 1'b0;
                end else begin
                    w_illegal = 1'b1;
                end
            end

            c_OPC_OP_IMM: begin
                // Only the shift-right form uses funct7[5] (SRAI); for every
                // other funct3 the upper bits are immediate, not opcode.
                w_alu_op    = {(w_funct3 == 3'b101) ? w_funct7[5] : 1'b0, w_funct3};
                w_sel_b     = c_SEL_B_IMM;
                w_writes_rd = 1'b1;
                w_imm32     = w_imm_i;
                if (w_funct3 == 3'b001) begin
                    w_imm32   = w_imm_shamt;
                    w_illegal = (w_funct7 != c_F7_ZERO);
                end else if (w_funct3 == 3'b101) begin
                    w_imm32   = w_imm_shamt;
                    w_illegal = (w_funct7 != c_F7_ZERO) && (w_funct7 != c_F7_ALT);
                end
            end

            c_OPC_LUI: begin
                w_sel_a     = c_SEL_A_ZERO;
                w_sel_b     = c_SEL_B_IMM;
                w_imm32     = w_imm_u;
                w_writes_rd = 1'b1;
            end

            c_OPC_AUIPC: begin
                w_sel_a     = c_SEL_A_PC;
                w_sel_b     = c_SEL_B_IMM;
                w_imm32     = w_imm_u;
                w_writes_rd = 1'b1;
            end

            c_OPC_JAL: begin
                // ALU forms the target pc + imm; the link value is produced
                // downstream from pc_o.
                w_sel_a     = c_SEL_A_PC;
                w_sel_b     = c_SEL_B_IMM;
                w_imm32     = w_imm_j;
                w_writes_rd = 1'b1;
                w_jump_raw  = 1'b1;
            end

            c_OPC_JALR: begin
                w_sel_a     = c_SEL_A_RS1;
                w_sel_b     = c_SEL_B_IMM;
                w_imm32     = w_imm_i;
                w_writes_rd = 1'b1;
                w_jump_raw  = 1'b1;
                w_illegal   = (w_funct3 != 3'b000);
            end

            c_OPC_BRANCH: begin
                // Compare via subtraction; the target adder lives elsewhere.
                w_alu_op  = c_ALU_SUB;
                w_imm32   = w_imm_b;
                w_br_raw  = 1'b1;
                w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end

            c_OPC_LOAD: begin
                w_sel_b     = c_SEL_B_IMM;
                w_imm32     = w_imm_i;
                w_writes_rd = 1'b1;
                w_ld_raw    = 1'b1;
            end

            c_OPC_STORE: begin
                w_sel_b  = c_SEL_B_IMM;
                w_imm32  = w_imm_s;
                w_st_raw = 1'b1;
            end

            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Side-effect flags are suppressed for illegal words so execute only
    // has to look at illegal_o to raise the trap.
    logic            w_rd_we;
    logic            w_br;
    logic            w_jump;
    logic            w_ld;
    logic            w_st;
    logic [XLEN-1:0] w_imm;

    assign w_rd_we = w_writes_rd & ~w_illegal & (w_rd != 5'd0);
    assign w_br    = w_br_raw    & ~w_illegal;
    assign w_jump  = w_jump_raw  & ~w_illegal;
    assign w_ld    = w_ld_raw    & ~w_illegal;
    assign w_st    = w_st_raw    & ~w_illegal;
    assign w_imm   = XLEN'($signed(w_imm32));

    // ------------------------------------------------------------------
    // Handshake and output register
    // ------------------------------------------------------------------
    logic            r_valid;
    logic [3:0]      r_alu_op;
    logic [1:0]      r_sel_a;
    logic            r_sel_b;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic            r_rd_we;
    logic            r_br;
    logic [2:0]      r_br_funct3;
    logic            r_jump;
    logic            r_ld;
    logic            r_st;
    logic            r_illegal;
    logic [XLEN-1:0] r_pc;

    logic w_in_ready;
    logic w_load;

    assign w_in_ready = ~r_valid | bus.out_ready_i;
    assign w_load     = bus.in_valid_i & w_in_ready;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid     <= 1'b0;
            r_alu_op    <= c_ALU_ADD;
            r_sel_a     <= 2'd0;
            r_sel_b     <= 1'b0;
            r_imm       <= '0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_rd_we     <= 1'b0;
            r_br        <= 1'b0;
            r_br_funct3 <= 3'd0;
            r_jump      <= 1'b0;
            r_ld        <= 1'b0;
            r_st        <= 1'b0;
            r_illegal   <= 1'b0;
            r_pc        <= RESET_PC;
        end else if (bus.flush_i) begin
            // Redirect wins over both a pending load and a stalled bundle.
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid     <= 1'b1;
            r_alu_op    <= w_alu_op;
            r_sel_a     <= w_sel_a;
            r_sel_b     <= w_sel_b;
            r_imm       <= w_imm;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_rd        <= w_rd;
            r_rd_we     <= w_rd_we;
            r_br        <= w_br;
            r_br_funct3 <= w_funct3;
            r_jump      <= w_jump;
            r_ld        <= w_ld;
            r_st        <= w_st;
            r_illegal   <= w_illegal;
            r_pc        <= bus.pc_i;
        end else if (bus.out_ready_i) begin
            // Consumed with nothing behind it: data fields keep last value.
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = r_valid;
    assign bus.alu_op_o    = r_alu_op;
    assign bus.sel_a_o     = r_sel_a;
    assign bus.sel_b_o     = r_sel_b;
    assign bus.imm_o       = r_imm;
    assign bus.rs1_o       = r_rs1;
    assign bus.rs2_o       = r_rs2;
    assign bus.rd_o        = r_rd;
    assign bus.rd_we_o     = r_rd_we;
    assign bus.br_o        = r_br;
    assign bus.br_funct3_o = r_br_funct3;
    assign bus.jump_o      = r_jump;
    assign bus.ld_o        = r_ld;
    assign bus.st_o        = r_st;
    assign bus.illegal_o   = r_illegal;
    assign bus.pc_o        = r_pc;

endmodule
`default_nettype wire
